// File: rtl/alu_pkg.sv
// Shared encodings for the ALU output stage: source selects, skid-buffer
// occupancy states and the result flag pair.
package alu_pkg;

    typedef enum logic [1:0] {
        OSEL_ADD = 2'd0,
        OSEL_SHF = 2'd1,
        OSEL_LOG = 2'd2
    } osel_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic z;
        logic n;
    } flags_t;

endpackage

// File: rtl/src_select.sv
// N-way result-bus multiplexer; any select at or beyond NSRC falls back to
// the last source (the logical unit in the default configuration).
module src_select #(
    parameter int W    = 8,
    parameter int NSRC = 3,
    parameter int SELW = 2
) (
    input  logic [NSRC*W-1:0] src_bus,
    input  logic [SELW-1:0]   sel,
    output logic [W-1:0]      y
);

    always_comb begin
        y = src_bus[(NSRC-1)*W +: W];
        for (int k = 0; k < NSRC - 1; k++) begin
            if (sel == SELW'(k)) begin
                y = src_bus[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/alu_out_stage.sv
// ALU output select with registered result/flags presented through a
// 2-entry skid buffer, plus a saturating count of downstream stall cycles.
module alu_out_stage
    import alu_pkg::*;
#(
    parameter int W    = 8,
    parameter int NSRC = 3,
    parameter int SELW = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSRC*W-1:0] src_bus,
    input  logic [SELW-1:0]   OSEL,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      Y,
    output logic              Z,
    output logic              N,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNTW-1:0]   stall_cnt,
    input  logic              stall_clr
);

    function automatic flags_t mk_flags(input logic [W-1:0] d);
        flags_t f;
        f.z = (d == '0);
        f.n = d[W-1];
        return f;
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---- p0: combinational select and flag generation ----
    logic [W-1:0] sel_y_p0;
    flags_t       sel_f_p0;

    src_select #(
        .W    (W),
        .NSRC (NSRC),
        .SELW (SELW)
    ) u_src_select (
        .src_bus (src_bus),
        .sel     (OSEL),
        .y       (sel_y_p0)
    );

    assign sel_f_p0 = mk_flags(sel_y_p0);

    // ---- p1: main/skid registers and occupancy FSM ----
    state_e       state;
    logic [W-1:0] main_y_p1;
    flags_t       main_f_p1;
    logic [W-1:0] skid_y_p1;
    flags_t       skid_f_p1;
    logic         acc;
    logic         pop;

    // Handshake decodes depend only on registered state, never on out_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_y_p1 <= '0;
            main_f_p1 <= '0;
            skid_y_p1 <= '0;
            skid_f_p1 <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_y_p1 <= sel_y_p0;
                        main_f_p1 <= sel_f_p0;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        skid_y_p1 <= sel_y_p0;
                        skid_f_p1 <= sel_f_p0;
                        state     <= TWO;
                    end else if (acc && pop) begin
                        main_y_p1 <= sel_y_p0;
                        main_f_p1 <= sel_f_p0;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_y_p1 <= skid_y_p1;
                        main_f_p1 <= skid_f_p1;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign Y = main_y_p1;
    assign Z = main_f_p1.z;
    assign N = main_f_p1.n;

    // ---- stall accounting ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
